// File: rtl/event_timestamp_fifo.sv
// event_timestamp_fifo
// Stamps each accepted event pulse with a free-running cycle timestamp,
// buffers the stamps in a small power-of-two FIFO and presents them on a
// valid/ready read port. Also keeps saturating accepted/dropped event
// counters and a sticky overflow flag for monitoring.
module event_timestamp_fifo #(
  parameter int TS_WIDTH  = 16,
  parameter int DEPTH     = 4,
  parameter int CNT_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic                     clear,
  input  logic                     event_pulse,
  input  logic                     rd_ready,
  output logic                     rd_valid,
  output logic [TS_WIDTH-1:0]      rd_data,
  output logic [CNT_WIDTH-1:0]     event_count,
  output logic [CNT_WIDTH-1:0]     drop_count,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [AW:0]          PTR_ONE = (AW+1)'(1);
  localparam logic [TS_WIDTH-1:0]  TS_ONE  = TS_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  // Stamp storage; contents are meaningless until written, so no reset.
  logic [TS_WIDTH-1:0]  mem_q [DEPTH];

  // Pointers carry one extra wrap bit so full and empty can be told apart.
  logic [AW:0]          wrPtr_q, wrPtr_d;
  logic [AW:0]          rdPtr_q, rdPtr_d;
  logic [TS_WIDTH-1:0]  ts_q, ts_d;
  logic [CNT_WIDTH-1:0] eventCount_q, eventCount_d;
  logic [CNT_WIDTH-1:0] dropCount_q, dropCount_d;
  logic                 overflow_q, overflow_d;

  logic                 fifoEmpty;
  logic                 fifoFull;
  logic                 pushReq;
  logic                 popReq;
  logic                 pushAccept;
  logic                 pushReject;
  logic                 memWrite;

  assign fifoEmpty  = (wrPtr_q == rdPtr_q);
  assign fifoFull   = (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]) &&
                      (wrPtr_q[AW] != rdPtr_q[AW]);

  // A pulse only counts while the block is enabled; a pop frees a slot in
  // the same cycle, so a full FIFO can still take a push alongside a pop.
  assign pushReq    = event_pulse && enable;
  assign popReq     = !fifoEmpty && rd_ready;
  assign pushAccept = pushReq && (!fifoFull || popReq);
  assign pushReject = pushReq && !pushAccept;
  assign memWrite   = pushAccept && !clear;

  assign rd_valid    = !fifoEmpty;
  assign rd_data     = mem_q[rdPtr_q[AW-1:0]];
  assign level       = wrPtr_q - rdPtr_q;
  assign event_count = eventCount_q;
  assign drop_count  = dropCount_q;
  assign overflow    = overflow_q;

  // Next-state logic: clear wins over everything, otherwise advance the
  // timestamp, pointers and monitoring counters for this cycle's activity.
  always_comb begin
    wrPtr_d      = wrPtr_q;
    rdPtr_d      = rdPtr_q;
    ts_d         = ts_q;
    eventCount_d = eventCount_q;
    dropCount_d  = dropCount_q;
    overflow_d   = overflow_q;

    if (clear) begin
      wrPtr_d      = '0;
      rdPtr_d      = '0;
      ts_d         = '0;
      eventCount_d = '0;
      dropCount_d  = '0;
      overflow_d   = 1'b0;
    end else begin
      if (enable) begin
        ts_d = ts_q + TS_ONE;
      end
      if (pushAccept) begin
        wrPtr_d = wrPtr_q + PTR_ONE;
        if (eventCount_q != CNT_MAX) begin
          eventCount_d = eventCount_q + CNT_ONE;
        end
      end
      if (pushReject) begin
        overflow_d = 1'b1;
        if (dropCount_q != CNT_MAX) begin
          dropCount_d = dropCount_q + CNT_ONE;
        end
      end
      if (popReq) begin
        rdPtr_d = rdPtr_q + PTR_ONE;
      end
    end
  end

  // Control and monitoring state, cleared immediately on reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrPtr_q      <= '0;
      rdPtr_q      <= '0;
      ts_q         <= '0;
      eventCount_q <= '0;
      dropCount_q  <= '0;
      overflow_q   <= 1'b0;
    end else begin
      wrPtr_q      <= wrPtr_d;
      rdPtr_q      <= rdPtr_d;
      ts_q         <= ts_d;
      eventCount_q <= eventCount_d;
      dropCount_q  <= dropCount_d;
      overflow_q   <= overflow_d;
    end
  end

  // Capture the pre-increment timestamp into the tail slot on accepted pushes.
  always_ff @(posedge clk) begin
    if (memWrite) begin
      mem_q[wrPtr_q[AW-1:0]] <= ts_q;
    end
  end

endmodule
